// File: rtl/rgb_color_encoder.sv
// rgb_color_encoder
// Maps a stream of 12-bit RGB pixels back to the palette (color_mode, color)
// pair that produces them. Pixels that are not in the palette resolve to the
// nearest entry by Manhattan distance, with the lowest index winning ties.
// Non-exact results that are handed to the consumer are tallied in a
// saturating miss counter.
//
// Two-stage pipeline under a single advance enable:
//   stage 1 : distances from the incoming pixel to all nine entries
//   stage 2 : min/argmin reduction -> palette code + exact flag
module rgb_color_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_red,
    input  logic [3:0]       in_green,
    input  logic [3:0]       in_blue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_color_mode,
    output logic [2:0]       out_color,
    output logic             out_exact,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] miss_count
);

    localparam int N_ENT = 9;

    // Palette RGB values, in tie-break order (index 0 has highest priority).
    localparam logic [11:0] PAL_RGB [0:N_ENT-1] = '{
        12'h000,  // black
        12'hFFF,  // white
        12'h888,  // gray
        12'h421,  // brown
        12'h0F0,  // green
        12'hF00,  // red
        12'hFF0,  // yellow
        12'h00F,  // blue
        12'hFA0   // orange
    };

    // Matching {color_mode, color} codes. Alias codes are never produced.
    localparam logic [3:0] PAL_CODE [0:N_ENT-1] = '{
        4'b0_000,
        4'b0_001,
        4'b0_010,
        4'b0_011,
        4'b1_000,
        4'b1_001,
        4'b1_010,
        4'b1_011,
        4'b1_100
    };

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Sum of three 4-bit magnitudes; 6 bits covers the 45 maximum.
    function automatic logic [5:0] manhattan(input logic [11:0] p, input logic [11:0] e);
        return {2'b00, abs_diff(p[11:8], e[11:8])}
             + {2'b00, abs_diff(p[7:4],  e[7:4])}
             + {2'b00, abs_diff(p[3:0],  e[3:0])};
    endfunction

    logic             en;
    logic [11:0]      pix_in;

    logic [5:0]       dist_d [0:N_ENT-1];
    logic [5:0]       dist_q [0:N_ENT-1];
    logic             s1_valid_q;

    logic [5:0]       best_dist;
    logic [3:0]       best_code;

    logic             out_valid_q;
    logic             out_mode_q;
    logic [2:0]       out_color_q;
    logic             out_exact_q;
    logic             out_mode_d;
    logic [2:0]       out_color_d;
    logic             out_exact_d;

    logic             xfer;
    logic [CNT_W-1:0] miss_count_q;
    logic [CNT_W-1:0] miss_count_d;

    // The whole pipeline moves together; only a held result blocks it.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign pix_in   = {in_red, in_green, in_blue};

    // Stage 1 combinational: distance to every palette entry in parallel.
    always_comb begin
        for (int k = 0; k < N_ENT; k++) begin
            dist_d[k] = manhattan(pix_in, PAL_RGB[k]);
        end
    end

    // Stage 1 register: valid plus the nine distances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            for (int k = 0; k < N_ENT; k++) begin
                dist_q[k] <= 6'd0;
            end
        end else if (en) begin
            s1_valid_q <= in_valid;
            for (int k = 0; k < N_ENT; k++) begin
                dist_q[k] <= dist_d[k];
            end
        end
    end

    // Stage 2 combinational: strict less-than scan so the lowest index keeps a tie.
    always_comb begin
        best_dist = dist_q[0];
        best_code = PAL_CODE[0];
        for (int k = 1; k < N_ENT; k++) begin
            if (dist_q[k] < best_dist) begin
                best_dist = dist_q[k];
                best_code = PAL_CODE[k];
            end
        end
    end

    // Stage 2 next-state: split the selected code and flag an exact hit.
    always_comb begin
        out_mode_d  = best_code[3];
        out_color_d = best_code[2:0];
        out_exact_d = (best_dist == 6'd0);
    end

    // Stage 2 register: result held stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
            out_color_q <= 3'b000;
            out_exact_q <= 1'b0;
        end else if (en) begin
            out_valid_q <= s1_valid_q;
            out_mode_q  <= out_mode_d;
            out_color_q <= out_color_d;
            out_exact_q <= out_exact_d;
        end
    end

    assign xfer = out_valid_q && out_ready;

    // Miss counter next-state: clear dominates, then saturating increment.
    always_comb begin
        miss_count_d = miss_count_q;
        if (clr_stats) begin
            miss_count_d = '0;
        end else if (xfer && !out_exact_q && (miss_count_q != CNT_MAX)) begin
            miss_count_d = miss_count_q + CNT_ONE;
        end
    end

    // Miss counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_count_q <= '0;
        end else begin
            miss_count_q <= miss_count_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_color_mode = out_mode_q;
    assign out_color      = out_color_q;
    assign out_exact      = out_exact_q;
    assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_rgb_color_encoder.sv
// Directed bench for rgb_color_encoder, built with a 4-bit miss counter so
// saturation is reachable quickly. Inputs change and outputs are sampled on
// the falling edge.
module tb_rgb_color_encoder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_red, in_green, in_blue;
    logic             out_valid;
    logic             out_ready;
    logic             out_color_mode;
    logic [2:0]       out_color;
    logic             out_exact;
    logic             clr_stats;
    logic [CNT_W-1:0] miss_count;

    int checks = 0;
    int errors = 0;

    logic [11:0] pix    [0:19];
    logic [3:0]  exp_mc [0:19];
    logic        exp_ex [0:19];

    rgb_color_encoder #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_red         (in_red),
        .in_green       (in_green),
        .in_blue        (in_blue),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_color_mode (out_color_mode),
        .out_color      (out_color),
        .out_exact      (out_exact),
        .clr_stats      (clr_stats),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] p);
        in_valid = v;
        in_red   = p[11:8];
        in_green = p[7:4];
        in_blue  = p[3:0];
    endtask

    task automatic set_vec(input int i, input logic [11:0] p, input logic [3:0] mc, input logic ex);
        pix[i]    = p;
        exp_mc[i] = mc;
        exp_ex[i] = ex;
    endtask

    // Back-to-back stream with out_ready=1; result i is expected exactly two
    // edges after it was presented, one per clock.
    task automatic stream(input string tag, input int n);
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            chk({tag, ".in_ready"}, {15'd0, in_ready}, 16'd1);
            if (i == 1) chk({tag, ".latency"}, {15'd0, out_valid}, 16'd0);
            if (i >= 2) begin
                chk($sformatf("%s[%0d].valid", tag, i-2), {15'd0, out_valid}, 16'd1);
                chk($sformatf("%s[%0d].code", tag, i-2), {12'd0, out_color_mode, out_color}, {12'd0, exp_mc[i-2]});
                chk($sformatf("%s[%0d].exact", tag, i-2), {15'd0, out_exact}, {15'd0, exp_ex[i-2]});
            end
            if (i < n) drive(1'b1, pix[i]);
            else       drive(1'b0, 12'h000);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        drive(1'b0, 12'h000);

        // Reset state
        @(negedge clk);
        chk("rst.in_ready",  {15'd0, in_ready}, 16'd1);
        chk("rst.out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst.code",      {12'd0, out_color_mode, out_color}, 16'd0);
        chk("rst.exact",     {15'd0, out_exact}, 16'd0);
        chk("rst.miss",      {12'd0, miss_count}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst.in_ready", {15'd0, in_ready}, 16'd1);

        // All nine palette entries, exact
        set_vec(0, 12'h000, 4'b0_000, 1'b1);
        set_vec(1, 12'hFFF, 4'b0_001, 1'b1);
        set_vec(2, 12'h888, 4'b0_010, 1'b1);
        set_vec(3, 12'h421, 4'b0_011, 1'b1);
        set_vec(4, 12'h0F0, 4'b1_000, 1'b1);
        set_vec(5, 12'hF00, 4'b1_001, 1'b1);
        set_vec(6, 12'hFF0, 4'b1_010, 1'b1);
        set_vec(7, 12'h00F, 4'b1_011, 1'b1);
        set_vec(8, 12'hFA0, 4'b1_100, 1'b1);
        stream("exact", 9);
        settle();
        chk("exact.miss", {12'd0, miss_count}, 16'd0);

        // Nearest match: EEE -> white (d=3), 444 -> brown (d=5)
        set_vec(0, 12'hEEE, 4'b0_001, 1'b0);
        set_vec(1, 12'h444, 4'b0_011, 1'b0);
        stream("near", 2);
        settle();
        chk("near.miss", {12'd0, miss_count}, 16'd2);

        // Ties: F50 red vs orange both 5 -> red; 080 green 7 beats black 8
        set_vec(0, 12'hF50, 4'b1_001, 1'b0);
        set_vec(1, 12'h080, 4'b1_000, 1'b0);
        stream("tie", 2);
        settle();
        chk("tie.miss", {12'd0, miss_count}, 16'd4);

        // Backpressure: black (exact), F10 -> red, 111 -> black
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 12'h000);
        @(negedge clk);
        drive(1'b1, 12'hF10);
        @(negedge clk);
        drive(1'b1, 12'h111);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            chk($sformatf("stall%0d.in_ready", s), {15'd0, in_ready}, 16'd0);
            chk($sformatf("stall%0d.valid", s), {15'd0, out_valid}, 16'd1);
            chk($sformatf("stall%0d.code", s), {12'd0, out_color_mode, out_color}, 16'h0);
            chk($sformatf("stall%0d.exact", s), {15'd0, out_exact}, 16'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b0, 12'h000);
        chk("bp1.valid", {15'd0, out_valid}, 16'd1);
        chk("bp1.code",  {12'd0, out_color_mode, out_color}, 16'h9);
        chk("bp1.exact", {15'd0, out_exact}, 16'd0);
        @(negedge clk);
        chk("bp2.valid", {15'd0, out_valid}, 16'd1);
        chk("bp2.code",  {12'd0, out_color_mode, out_color}, 16'h0);
        chk("bp2.exact", {15'd0, out_exact}, 16'd0);
        @(negedge clk);
        chk("bp.no_dup", {15'd0, out_valid}, 16'd0);
        chk("bp.miss",   {12'd0, miss_count}, 16'd6);

        // Saturation: 20 misses on a 4-bit counter end at F
        for (int i = 0; i < 20; i++) set_vec(i, 12'hEEE, 4'b0_001, 1'b0);
        stream("sat", 20);
        settle();
        chk("sat.miss", {12'd0, miss_count}, 16'hF);

        // Clear coinciding with a miss transfer wins
        @(negedge clk);
        drive(1'b1, 12'hEEE);
        @(negedge clk);
        drive(1'b0, 12'h000);
        @(negedge clk);
        chk("clr.valid", {15'd0, out_valid}, 16'd1);
        chk("clr.exact", {15'd0, out_exact}, 16'd0);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        chk("clr.miss",  {12'd0, miss_count}, 16'd0);
        chk("clr.drain", {15'd0, out_valid}, 16'd0);
        set_vec(0, 12'hEEE, 4'b0_001, 1'b0);
        stream("after_clr", 1);
        settle();
        chk("after_clr.miss", {12'd0, miss_count}, 16'd1);

        // Reset with two pixels in flight
        @(negedge clk);
        drive(1'b1, 12'h0F0);
        @(negedge clk);
        drive(1'b1, 12'hFFF);
        @(negedge clk);
        drive(1'b0, 12'h000);
        chk("mid.valid_before", {15'd0, out_valid}, 16'd1);
        chk("mid.code_before",  {12'd0, out_color_mode, out_color}, 16'h8);
        #2 rst = 1'b1;
        #1;
        chk("mid.async_valid", {15'd0, out_valid}, 16'd0);
        chk("mid.in_ready",    {15'd0, in_ready}, 16'd1);
        chk("mid.code",        {12'd0, out_color_mode, out_color}, 16'h0);
        chk("mid.miss",        {12'd0, miss_count}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk($sformatf("mid.stale%0d", s), {15'd0, out_valid}, 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
